// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double-dabble),
// one input bit per clock. Feeds the 4-digit display top; digits change only when a
// conversion completes, so the multiplexed display never shows partial results.
//
// Parameters:
//   WIDTH   - binary input width, 4..14.
//   MAX_VAL - saturation limit, must be <= 9999 and <= 2**WIDTH-1.
//             Inputs above it convert as MAX_VAL and raise overflow.
//
// Ports:
//   clk            - system clock, rising edge.
//   reset          - asynchronous active-high reset; aborts a conversion in progress.
//   start          - conversion request, sampled only while idle.
//   bin_in         - unsigned binary value, sampled on the accepted start edge.
//   Thousands_Data - BCD thousands digit (registered).
//   Hundreds_Data  - BCD hundreds digit (registered).
//   Tens_Data      - BCD tens digit (registered).
//   Ones_Data      - BCD ones digit (registered).
//   busy           - high from the start edge until the result edge.
//   done           - one-cycle pulse in the cycle after the result edge.
//   overflow       - registered with the digits; last captured bin_in exceeded MAX_VAL.
//
// Timing: start accepted on edge E0, shifts on E1..E_WIDTH, digits update on
// E_(WIDTH+1). A start held high restarts on the edge where done is high, giving
// one result every WIDTH+2 cycles.

module bin_to_bcd_seq #(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic [3:0]       Thousands_Data,
  output logic [3:0]       Hundreds_Data,
  output logic [3:0]       Tens_Data,
  output logic [3:0]       Ones_Data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned BcdW = 16;
  localparam int unsigned TotW = BcdW + WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] MaxValW  = WIDTH'(MAX_VAL);
  localparam logic [CntW-1:0]  LastStep = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLatch = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [TotW-1:0]   sr_q, sr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_flag_q, ovf_flag_d;
  logic [BcdW-1:0]   digits_q, digits_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  // Input saturation. The compare is done at 32 bits so a MAX_VAL wider than
  // WIDTH (i.e. 2**WIDTH-1 <= MAX_VAL) simply never triggers.
  logic              bin_ovf;
  logic [WIDTH-1:0]  bin_sat;

  always_comb begin
    bin_ovf = (32'(bin_in) > MAX_VAL);
    bin_sat = bin_ovf ? MaxValW : bin_in;
  end

  // Add-3 correction on every BCD nibble of the current register, applied
  // before the shift of the same edge.
  logic [TotW-1:0] sr_adj;

  always_comb begin
    sr_adj = sr_q;
    for (int d = 0; d < 4; d++) begin
      if (sr_q[WIDTH + 4*d +: 4] >= 4'd5) begin
        sr_adj[WIDTH + 4*d +: 4] = sr_q[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d       = {{BcdW{1'b0}}, bin_sat};
          ovf_flag_d = bin_ovf;
          cnt_d      = '0;
          state_d    = StShift;
        end
      end

      StShift: begin
        sr_d  = {sr_adj[TotW-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          state_d = StLatch;
        end
      end

      StLatch: begin
        digits_d   = sr_q[TotW-1 -: BcdW];
        overflow_d = ovf_flag_q;
        done_d     = 1'b1;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    Thousands_Data = digits_q[15:12];
    Hundreds_Data  = digits_q[11:8];
    Tens_Data      = digits_q[7:4];
    Ones_Data      = digits_q[3:0];
    busy           = (state_q != StIdle);
    done           = done_q;
    overflow       = overflow_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (default WIDTH=14, MAX_VAL=9999).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_bin_to_bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        busy, done, overflow;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  bin_to_bcd_seq #(
    .WIDTH   (14),
    .MAX_VAL (9999)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .bin_in         (bin_in),
    .Thousands_Data (thousands),
    .Hundreds_Data  (hundreds),
    .Tens_Data      (tens),
    .Ones_Data      (ones),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {thousands, hundreds, tens, ones};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Launch one conversion from idle (called at a falling edge) and follow it to
  // the done cycle. Counts busy cycles and flags any digit change before done.
  task automatic run_conv(input logic [13:0] v, input logic [15:0] prev,
                          output int busy_cycles, output bit got_done, output bit held);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start       = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    held        = 1'b1;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        if (digits() !== prev) held = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic [13:0] value;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          bc;
    bit          gd;
    bit          hd;
    logic [15:0] prev;
    int          dones;

    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd10,    16'h0010, 1'b0};
    vecs[4] = '{14'd12000, 16'h9999, 1'b1};
    vecs[5] = '{14'd42,    16'h0042, 1'b0};
    vecs[6] = '{14'd10000, 16'h9999, 1'b1};
    vecs[7] = '{14'd9998,  16'h9998, 1'b0};
    vecs[8] = '{14'd16383, 16'h9999, 1'b1};
    vecs[9] = '{14'd807,   16'h0807, 1'b0};

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    check("reset_digits",   32'(digits()), 32'h0);
    check("reset_busy",     32'(busy),     32'h0);
    check("reset_done",     32'(done),     32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    prev = 16'h0000;
    foreach (vecs[i]) begin
      run_conv(vecs[i].value, prev, bc, gd, hd);
      check($sformatf("v%0d_done_seen", i), 32'(gd), 32'h1);
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd15);
      check($sformatf("v%0d_digits", i), 32'(digits()), 32'(vecs[i].bcd));
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'h0);
      check($sformatf("v%0d_digits_held", i), 32'(hd), 32'h1);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'h0);
      prev = vecs[i].bcd;
    end

    // Start while busy is ignored.
    start  = 1'b1;
    bin_in = 14'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd1111;
    @(negedge clk);
    start = 1'b0;
    gd    = 1'b0;
    for (int i = 0; i < 30 && !gd; i++) begin
      if (done) gd = 1'b1;
      else @(negedge clk);
    end
    check("ign_done_seen", 32'(gd), 32'h1);
    check("ign_digits", 32'(digits()), 32'h5678);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ign_no_second_done", 32'(dones), 32'h0);
    check("ign_digits_kept", 32'(digits()), 32'h5678);

    // Asynchronous reset mid-conversion.
    start  = 1'b1;
    bin_in = 14'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_digits",   32'(digits()), 32'h0);
    check("arst_busy",     32'(busy),     32'h0);
    check("arst_done",     32'(done),     32'h0);
    check("arst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("arst_idle_after", 32'(busy), 32'h0);
    run_conv(14'd8765, 16'h0000, bc, gd, hd);
    check("arst_conv_done", 32'(gd), 32'h1);
    check("arst_conv_busy", 32'(bc), 32'd15);
    check("arst_conv_digits", 32'(digits()), 32'h8765);

    // Start held high: back-to-back conversions every 16 cycles.
    begin
      logic [13:0] vals[3];
      logic [15:0] exps[3];
      logic [15:0] held;
      int          k;
      int          cyc;
      int          last;
      bit          stable;
      vals[0] = 14'd100; vals[1] = 14'd200; vals[2] = 14'd300;
      exps[0] = 16'h0100; exps[1] = 16'h0200; exps[2] = 16'h0300;
      held   = 16'h8765;
      k      = 0;
      cyc    = 0;
      last   = 0;
      stable = 1'b1;
      start  = 1'b1;
      bin_in = vals[0];
      for (int i = 0; i < 80 && k < 3; i++) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          check($sformatf("b2b_digits_%0d", k), 32'(digits()), 32'(exps[k]));
          if (k > 0) check($sformatf("b2b_period_%0d", k), 32'(cyc - last), 32'd16);
          last = cyc;
          held = exps[k];
          k++;
          if (k < 3) bin_in = vals[k];
          else start = 1'b0;
        end else if (digits() !== held) begin
          stable = 1'b0;
        end
      end
      start = 1'b0;
      check("b2b_all_done", 32'(k), 32'd3);
      check("b2b_stable", 32'(stable), 32'h1);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
